// File: rtl/hex_serializer_pkg.sv
// Shared constants for the hex serializer: ASCII codes and FSM state encoding.
package hex_serializer_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIGIT = 2'd1;
    localparam logic [1:0] ST_CR    = 2'd2;
    localparam logic [1:0] ST_LF    = 2'd3;

endpackage

// File: rtl/hex_serializer_nibble_to_ascii.sv
// Maps a 4-bit nibble to its uppercase ASCII hex character, zero-extended to B bits.
module nibble_to_ascii
    import hex_serializer_pkg::*;
#(
    parameter int B = 8
) (
    input  logic [3:0]   nib_i,
    output logic [B-1:0] ascii_o
);

    logic [7:0] code;

    always_comb begin
        if (nib_i < 4'd10) code = ASCII_0 + {4'h0, nib_i};
        else               code = ASCII_A + {4'h0, nib_i} - 8'd10;
        ascii_o       = '0;
        ascii_o[7:0]  = code;
    end

endmodule

// File: rtl/hex_serializer.sv
// Formats an L-byte value as 2*L uppercase ASCII hex chars, MSB nibble first,
// optionally followed by CR LF, one char per out_valid/out_ready beat.
module hex_serializer
    import hex_serializer_pkg::*;
#(
    parameter int B    = 8,
    parameter int L    = 1,
    parameter bit CRLF = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [L*B-1:0] in_num,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [B-1:0]   out_char,
    output logic           out_last,
    output logic           busy
);

    localparam int W   = L * B;
    localparam int NCH = 2 * L;
    localparam int CW  = $clog2(NCH);
    localparam logic [CW-1:0] CNT_FIRST = CW'(NCH - 1);
    localparam logic [B-1:0]  CHAR_CR   = B'(ASCII_CR);
    localparam logic [B-1:0]  CHAR_LF   = B'(ASCII_LF);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          valid_q, valid_d;
    logic [B-1:0]  char_q, char_d;
    logic          last_q, last_d;

    logic          beat, done, accept;
    logic [3:0]    nib;
    logic [B-1:0]  nib_char;

    assign beat     = valid_q && out_ready;
    assign done     = beat && last_q;
    assign in_ready = (state_q == ST_IDLE) || done;
    assign accept   = in_valid && in_ready;

    // One converter serves both the first char of a new value and every later shift.
    assign nib = accept ? in_num[W-1 -: 4] : sh_q[W-5 -: 4];

    nibble_to_ascii #(.B(B)) u_n2a (
        .nib_i   (nib),
        .ascii_o (nib_char)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        valid_d = valid_q;
        char_d  = char_q;
        last_d  = last_q;
        if (accept) begin
            sh_d    = in_num;
            cnt_d   = CNT_FIRST;
            state_d = ST_DIGIT;
            valid_d = 1'b1;
            char_d  = nib_char;
            last_d  = 1'b0;
        end else if (beat) begin
            case (state_q)
                ST_DIGIT: begin
                    if (cnt_q != '0) begin
                        sh_d   = sh_q << 4;
                        cnt_d  = cnt_q - CW'(1);
                        char_d = nib_char;
                        last_d = !CRLF && (cnt_q == CW'(1));
                    end else if (CRLF) begin
                        state_d = ST_CR;
                        char_d  = CHAR_CR;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        char_d  = '0;
                        last_d  = 1'b0;
                    end
                end
                ST_CR: begin
                    state_d = ST_LF;
                    char_d  = CHAR_LF;
                    last_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    char_d  = '0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            char_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            char_q  <= char_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign busy      = valid_q;
    assign out_char  = char_q;
    assign out_last  = last_q;

endmodule
